// File: rtl/toy_bus_age_mtx_arb.sv
// Age-matrix slot tracker with oldest-first one-hot selection and a lowest-index
// free-slot pointer. Only the upper triangle of the age matrix is stored.
module toy_bus_age_mtx_arb #(
  parameter int N       = 4,
  parameter int OUT_REG = 0,
  parameter int CNT_W   = $clog2(N+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     alloc_en,
  input  logic [N-1:0]     dealloc_en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     sel_oh,
  output logic             sel_vld,
  output logic [N-1:0]     free_oh,
  output logic             full,
  output logic [N-1:0]     vld,
  output logic [CNT_W-1:0] vld_cnt,
  output logic [N*N-1:0]   age_rows,
  output logic             alloc_err
);

  localparam int NPAIR = N * (N - 1) / 2;

  // Packed index of pair (i,j), i<j, within the stored upper triangle.
  function automatic int pair_idx(input int i, input int j);
    return i * N - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  logic [NPAIR-1:0] b_reg;
  logic [NPAIR-1:0] b_next;
  logic [N-1:0]     vld_reg;
  logic [N-1:0]     vld_next;
  logic             alloc_err_reg;
  logic             alloc_err_next;
  logic [N*N-1:0]   older;
  logic [N-1:0]     cand;
  logic [N-1:0]     sel_comb;
  logic             win;
  logic [N-1:0]     empty_slots;
  logic [CNT_W-1:0] cnt;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        if (gi == gj) begin : g_diag
          assign older[gi*N+gj] = 1'b0;
        end else if (gi < gj) begin : g_upper
          localparam int IDX = pair_idx(gi, gj);
          // A younger allocation on j wins over i; both at once keeps lower index older.
          assign b_next[IDX] = alloc_en[gj] ? 1'b1 :
                               alloc_en[gi] ? 1'b0 : b_reg[IDX];
          assign older[gi*N+gj] = b_reg[IDX];
        end else begin : g_lower
          assign older[gi*N+gj] = ~b_reg[pair_idx(gj, gi)];
        end
      end
    end
  endgenerate

  assign vld_next       = alloc_en | (vld_reg & ~dealloc_en);
  assign alloc_err_next = alloc_err_reg | (|(alloc_en & vld_reg & ~dealloc_en));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_reg         <= '0;
      vld_reg       <= '0;
      alloc_err_reg <= 1'b0;
    end else begin
      b_reg         <= b_next;
      vld_reg       <= vld_next;
      alloc_err_reg <= alloc_err_next;
    end
  end

  // Stale ordering of released slots is harmless because cand masks by vld.
  always_comb begin
    cand     = req & vld_reg;
    sel_comb = '0;
    win      = 1'b0;
    for (int k = 0; k < N; k++) begin
      win = cand[k];
      for (int j = 0; j < N; j++) begin
        if (j != k && cand[j] && !older[k*N+j]) win = 1'b0;
      end
      sel_comb[k] = win;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [N-1:0] sel_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_reg <= '0;
        else        sel_reg <= sel_comb;
      end
      assign sel_oh = sel_reg;
    end else begin : g_out_comb
      assign sel_oh = sel_comb;
    end
  endgenerate

  always_comb begin
    cnt = '0;
    for (int k = 0; k < N; k++) cnt = cnt + CNT_W'(vld_reg[k]);
  end

  assign empty_slots = ~vld_reg;
  assign free_oh     = empty_slots & (~empty_slots + {{(N-1){1'b0}}, 1'b1});
  assign full        = &vld_reg;
  assign sel_vld     = |sel_oh;
  assign vld         = vld_reg;
  assign vld_cnt     = cnt;
  assign age_rows    = older;
  assign alloc_err   = alloc_err_reg;

endmodule
